dm_pipelined: RTL and testbench

- Parametrised data memory for the SiliCore cores; next generation of the fixed 256x32 data memory.
- Generalised in width and depth; adds per-byte write enables and a selectable 1- or 2-cycle registered read latency.
- Adds a req/ready handshake with rvalid, an out-of-range error flag, and an optional post-reset clear sequencer.
- Sits between the core's MEM stage (or the single-cycle datapath) and the memory array; all logic is on the rising edge of clock.

---
 rtl/dm_pkg.sv | 24 ++
 rtl/dm_array.sv | 55 +++++
 rtl/dm_pipelined.sv | 175 +++++++++++++++++
 tb/tb_dm_pipelined.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared state encoding and elaboration helpers for the parametrised data memory.
package dm_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dm_state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Storage array: byte-masked synchronous write port, synchronous read port
// that can be forced to return zero for out-of-range reads.
module dm_array
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [lane_count(DATA_WIDTH)-1:0] wr_be,
    input  logic                              rd_en,
    input  logic                              rd_zero,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [DATA_WIDTH-1:0]             rd_data
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int IW    = index_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [IW-1:0]         wr_idx_s;
    logic [IW-1:0]         rd_idx_s;

    assign wr_idx_s = wr_addr[IW-1:0];
    assign rd_idx_s = rd_addr[IW-1:0];

    // Byte-masked write; the caller only enables in-range addresses.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_idx_s][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register holds between reads; out-of-range reads capture zero.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_zero ? {DATA_WIDTH{1'b0}} : mem_r[rd_idx_s];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dm_pipelined.sv
// Data memory front end: clear sequencer, req/ready handshake, 1- or 2-cycle
// read pipeline and out-of-range error reporting around dm_array.
module dm_pipelined
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              req,
    input  logic                              we,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [lane_count(DATA_WIDTH)-1:0] be,
    output logic                              ready,
    output logic                              rvalid,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              err,
    output logic                              busy_clear
);

    localparam int             LANES      = lane_count(DATA_WIDTH);
    localparam int             CW         = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]  LAST_C     = CW'(DEPTH - 1);
    localparam dm_state_e      RESET_ST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic           RESET_BUSY = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("dm_pipelined: RD_LATENCY must be 1 or 2");
    end
    if (((DATA_WIDTH % 8) != 0) || (DEPTH < 1) || (DEPTH > (2 ** ADDR_WIDTH))) begin : g_bad_geometry
        $error("dm_pipelined: illegal DATA_WIDTH/DEPTH/ADDR_WIDTH combination");
    end

    dm_state_e             state_r;
    logic [CW-1:0]         clr_cnt_r;
    logic                  ready_r;
    logic                  busy_clear_r;
    logic                  rvalid_r;
    logic                  err_r;

    logic                  acc_s;
    logic                  rd_acc_s;
    logic                  in_range_s;
    logic                  clearing_s;
    logic                  arr_we_s;
    logic [ADDR_WIDTH-1:0] arr_addr_s;
    logic [DATA_WIDTH-1:0] arr_wdata_s;
    logic [LANES-1:0]      arr_be_s;
    logic [DATA_WIDTH-1:0] arr_rdata_s;

    // Request qualification; nothing is accepted on an edge where reset is held.
    always_comb begin
        acc_s      = req & ready_r & reset_n;
        in_range_s = ({1'b0, addr} < DEPTH_C);
        rd_acc_s   = acc_s & ~we;
        clearing_s = (state_r == ST_CLEAR) & reset_n;
    end

    // Single write port: the clear sequencer owns it while clearing.
    always_comb begin
        if (clearing_s) begin
            arr_we_s    = 1'b1;
            arr_addr_s  = clr_cnt_r[ADDR_WIDTH-1:0];
            arr_wdata_s = {DATA_WIDTH{1'b0}};
            arr_be_s    = {LANES{1'b1}};
        end else begin
            arr_we_s    = acc_s & we & in_range_s;
            arr_addr_s  = addr;
            arr_wdata_s = wdata;
            arr_be_s    = be;
        end
    end

    // Clear/run sequencer with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= RESET_ST;
            clr_cnt_r    <= {CW{1'b0}};
            ready_r      <= 1'b0;
            busy_clear_r <= RESET_BUSY;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_C) begin
                        state_r      <= ST_RUN;
                        clr_cnt_r    <= {CW{1'b0}};
                        ready_r      <= 1'b1;
                        busy_clear_r <= 1'b0;
                    end else begin
                        clr_cnt_r    <= clr_cnt_r + CW'(1);
                        ready_r      <= 1'b0;
                        busy_clear_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_r      <= 1'b1;
                    busy_clear_r <= 1'b0;
                end
                default: begin
                    state_r      <= RESET_ST;
                    clr_cnt_r    <= {CW{1'b0}};
                    ready_r      <= 1'b0;
                    busy_clear_r <= RESET_BUSY;
                end
            endcase
        end
    end

    dm_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (arr_we_s),
        .wr_addr (arr_addr_s),
        .wr_data (arr_wdata_s),
        .wr_be   (arr_be_s),
        .rd_en   (rd_acc_s),
        .rd_zero (~in_range_s),
        .rd_addr (addr),
        .rd_data (arr_rdata_s)
    );

    if (RD_LATENCY == RD_LATENCY_MIN) begin : g_lat1
        // Array read register is the output; err covers both read and write misses.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                rvalid_r <= 1'b0;
                err_r    <= 1'b0;
            end else begin
                rvalid_r <= rd_acc_s;
                err_r    <= acc_s & ~in_range_s;
            end
        end
        assign rdata = arr_rdata_s;
    end else begin : g_lat2
        logic                  v1_r;
        logic                  e1_r;
        logic [DATA_WIDTH-1:0] d2_r;

        // Extra output stage; write errors still report one cycle after acceptance.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                v1_r     <= 1'b0;
                e1_r     <= 1'b0;
                rvalid_r <= 1'b0;
                err_r    <= 1'b0;
                d2_r     <= {DATA_WIDTH{1'b0}};
            end else begin
                v1_r     <= rd_acc_s;
                e1_r     <= rd_acc_s & ~in_range_s;
                rvalid_r <= v1_r;
                err_r    <= e1_r | (acc_s & we & ~in_range_s);
                if (v1_r) begin
                    d2_r <= arr_rdata_s;
                end
            end
        end
        assign rdata = d2_r;
    end

    assign ready      = ready_r;
    assign rvalid     = rvalid_r;
    assign err        = err_r;
    assign busy_clear = busy_clear_r;

endmodule

// File: tb/tb_dm_pipelined.sv
// Four differently configured instances share one stimulus stream; a
// per-instance memory/latency model predicts every output each cycle.
module tb_dm_pipelined;

    localparam int N = 4;
    localparam int DEP [N] = '{16, 200, 256, 8};
    localparam int LAT [N] = '{1, 2, 1, 2};
    localparam int CLR [N] = '{1, 1, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         req;
    logic         we;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic [N-1:0] ready;
    logic [N-1:0] rvalid;
    logic [N-1:0] err;
    logic [N-1:0] busy_clear;
    logic [31:0]  rdata [N];

    dm_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_d0 (
        .clock(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]), .busy_clear(busy_clear[0]));
    dm_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u_d1 (
        .clock(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]), .busy_clear(busy_clear[1]));
    dm_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_d2 (
        .clock(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready[2]), .rvalid(rvalid[2]), .rdata(rdata[2]), .err(err[2]), .busy_clear(busy_clear[2]));
    dm_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(8), .RD_LATENCY(2), .CLEAR_ON_RESET(0)) u_d3 (
        .clock(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready[3]), .rvalid(rvalid[3]), .rdata(rdata[3]), .err(err[3]), .busy_clear(busy_clear[3]));

    // Reference model state: contents with per-byte "known" flags, cycles
    // since reset release, and read results waiting to emerge (slot 0 = now).
    logic [31:0] mm [N][256];
    logic [3:0]  kn [N][256];
    int          rel [N];
    bit          ready_m [N];
    bit          vs [N][2];
    bit          es [N][2];
    logic [31:0] ds [N][2];
    bit          ks [N][2];
    logic [31:0] last_d [N];
    bit          last_k [N];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic model_edge(input int d);
        bit acc;
        bit inr;
        int slot;
        if (!reset_n) begin
            rel[d]     = 0;
            ready_m[d] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vs[d][k] = 1'b0;
                es[d][k] = 1'b0;
            end
            last_d[d] = 32'h0;
            last_k[d] = 1'b1;
            if (CLR[d] != 0) begin
                for (int a = 0; a < 256; a++) begin
                    mm[d][a] = 32'h0;
                    kn[d][a] = 4'hF;
                end
            end
        end else begin
            acc = req && ready_m[d];
            vs[d][0] = vs[d][1]; es[d][0] = es[d][1]; ds[d][0] = ds[d][1]; ks[d][0] = ks[d][1];
            vs[d][1] = 1'b0;     es[d][1] = 1'b0;
            inr = (int'(addr) < DEP[d]);
            if (acc && we) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            mm[d][addr][8*b +: 8] = wdata[8*b +: 8];
                            kn[d][addr][b]        = 1'b1;
                        end
                    end
                end else begin
                    es[d][0] = 1'b1;
                end
            end else if (acc) begin
                slot = LAT[d] - 1;
                vs[d][slot] = 1'b1;
                es[d][slot] = es[d][slot] | !inr;
                ds[d][slot] = inr ? mm[d][addr] : 32'h0;
                ks[d][slot] = inr ? (kn[d][addr] == 4'hF) : 1'b1;
            end
            if (vs[d][0]) begin
                last_d[d] = ds[d][0];
                last_k[d] = ks[d][0];
            end
            if (rel[d] < 1000) rel[d]++;
            ready_m[d] = (CLR[d] != 0) ? (rel[d] >= DEP[d]) : (rel[d] >= 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            model_edge(d);
            chk("ready", d, 32'(ready[d]), 32'(ready_m[d]));
            chk("busy_clear", d, 32'(busy_clear[d]), 32'((CLR[d] != 0) && (rel[d] < DEP[d])));
            chk("rvalid", d, 32'(rvalid[d]), 32'(vs[d][0]));
            chk("err", d, 32'(err[d]), 32'(es[d][0]));
            if (last_k[d]) chk("rdata", d, rdata[d], last_d[d]);
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [7:0] a, input logic [31:0] dt, input logic [3:0] b);
        req = r; we = w; addr = a; wdata = dt; be = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic wait_all_ready();
        int n;
        n = 0;
        while (ready !== 4'hF && n < 300) begin
            idle(1);
            n++;
        end
        chk("ready_timeout", 0, 32'(ready), 32'hF);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = 8'h0; wdata = 32'h0; be = 4'h0;
        for (int d = 0; d < N; d++) begin
            rel[d] = 0; ready_m[d] = 1'b0; last_d[d] = 32'h0; last_k[d] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vs[d][k] = 1'b0; es[d][k] = 1'b0; ds[d][k] = 32'h0; ks[d][k] = 1'b0;
            end
            for (int a = 0; a < 256; a++) begin
                mm[d][a] = 32'h0; kn[d][a] = 4'h0;
            end
        end

        // Reset, abort the clear part-way, then let it run to completion.
        idle(3);
        reset_n = 1'b1;
        idle(8);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        n = 0;
        while (ready[0] !== 1'b1 && n < 300) begin
            idle(1);
            n++;
        end
        chk("clear_cycles", 0, 32'(n), 32'd16);
        wait_all_ready();

        drive(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
        idle(2);
        for (int d = 0; d < 3; d++) chk("clear_zero", d, rdata[d], 32'h0);

        // Byte-enable merge.
        drive(1'b1, 1'b1, 8'd3, 32'hAABBCCDD, 4'b1111);
        drive(1'b1, 1'b1, 8'd3, 32'h11223344, 4'b0101);
        drive(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
        idle(2);
        for (int d = 0; d < N; d++) chk("byte_enable", d, rdata[d], 32'hAA22CC44);

        // Back-to-back reads return in order.
        drive(1'b1, 1'b1, 8'd1, 32'd10, 4'hF);
        drive(1'b1, 1'b1, 8'd2, 32'd20, 4'hF);
        drive(1'b1, 1'b1, 8'd3, 32'd30, 4'hF);
        drive(1'b1, 1'b0, 8'd1, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
        idle(3);
        for (int d = 0; d < N; d++) chk("order_last", d, rdata[d], 32'd30);

        // Read immediately after write, and a no-op be=0 write.
        drive(1'b1, 1'b1, 8'd7, 32'hDEADBEEF, 4'hF);
        drive(1'b1, 1'b0, 8'd7, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 8'd7, 32'h12345678, 4'h0);
        drive(1'b1, 1'b0, 8'd7, 32'h0, 4'h0);
        idle(2);
        for (int d = 0; d < N; d++) chk("read_after_write", d, rdata[d], 32'hDEADBEEF);

        // Out-of-range write and reads (in range only for the 256-deep instance).
        drive(1'b1, 1'b1, 8'd250, 32'h5, 4'hF);
        drive(1'b1, 1'b0, 8'd250, 32'h0, 4'h0);
        idle(2);
        chk("oor_read_zero", 1, rdata[1], 32'h0);
        chk("in_range_250", 2, rdata[2], 32'h5);
        drive(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
        idle(3);

        // Reset right after a read is accepted: the read must never return.
        drive(1'b1, 1'b0, 8'd1, 32'h0, 4'h0);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        wait_all_ready();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
                  32'($urandom),
                  4'($urandom_range(0, 15)));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
